// File: rtl/frame_sequencer.sv
// Run sequencer: walks a frame through FETCH/CORE row batches, then hands off to VGA.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module frame_sequencer #(
    parameter int unsigned MAX_ROW   = 240,
    parameter int unsigned MAX_COL   = 320,
    parameter int unsigned TILE_ROWS = 4,
    parameter int unsigned ROW_W     = 9,
    parameter int unsigned COL_W     = 9,
    parameter int unsigned TMO_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             vga_run_i,
    input  logic             fetch_done_i,
    input  logic             core_done_i,
    output logic             fetch_start_o,
    output logic [ROW_W-1:0] fetch_row_o,
    output logic [ROW_W-1:0] fetch_rows_o,
    output logic [COL_W-1:0] fetch_cols_o,
    output logic             core_start_o,
    output logic             vga_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0]       state_o
);

    localparam int unsigned RW1 = ROW_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CORE    = 3'd2;
    localparam logic [2:0] S_VGA_RUN = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam logic [ROW_W-1:0] ROWS_RST =
        (TILE_ROWS < MAX_ROW) ? ROW_W'(TILE_ROWS) : ROW_W'(MAX_ROW);

    logic [2:0]       r_state;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] r_rows;
    logic             r_fetch_start;
    logic             r_core_start;
    logic             r_vga_en;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic [ROW_W-1:0] w_rows_nxt;
    logic             w_fetch_start_nxt;
    logic             w_core_start_nxt;
    logic [RW1-1:0]   w_row_sum;
    logic [RW1-1:0]   w_rem;
    logic             w_timeout;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_error;

    // Counter reaches all-ones on the same edge the FSM moves to S_ERR.
    assign w_timeout = (r_tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo   <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_tmo <= '0;
            else if (r_state == S_FETCH || r_state == S_CORE)
                r_tmo <= r_tmo + TMO_W'(1);

            if (w_state_nxt == S_ERR && r_state != S_ERR)
                r_error <= 1'b1;
            else if (r_state == S_IDLE && start_i && !abort_i)
                r_error <= 1'b0;
        end
    end

    assign error_o = r_error;
`else
    assign w_timeout = 1'b0;
    assign error_o   = 1'b0 && (TMO_W > 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_rows        <= ROWS_RST;
            r_fetch_start <= 1'b0;
            r_core_start  <= 1'b0;
            r_vga_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_row         <= w_row_nxt;
            r_rows        <= w_rows_nxt;
            r_fetch_start <= w_fetch_start_nxt;
            r_core_start  <= w_core_start_nxt;
            r_vga_en      <= (w_state_nxt == S_VGA_RUN);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_done        <= (w_state_nxt == S_DONE);
        end
    end

    // Next state and next registered outputs; a start pulse still high means first cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_row_sum   = {1'b0, r_row} + RW1'(TILE_ROWS);

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_row_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_done_i && !r_fetch_start)
                    w_state_nxt = S_CORE;
                else if (w_timeout)
                    w_state_nxt = S_ERR;
            end
            S_CORE: begin
                if (core_done_i && !r_core_start) begin
                    if (w_row_sum < RW1'(MAX_ROW)) begin
                        w_row_nxt   = w_row_sum[ROW_W-1:0];
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = vga_run_i ? S_VGA_RUN : S_DONE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_VGA_RUN: begin
                if (!vga_run_i)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR: begin
                if (!start_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (abort_i) begin
            w_state_nxt = S_IDLE;
            w_row_nxt   = '0;
        end

        w_rem             = RW1'(MAX_ROW) - {1'b0, w_row_nxt};
        w_rows_nxt        = (w_rem < RW1'(TILE_ROWS)) ? w_rem[ROW_W-1:0] : ROW_W'(TILE_ROWS);
        w_fetch_start_nxt = (w_state_nxt == S_FETCH) && (r_state != S_FETCH);
        w_core_start_nxt  = (w_state_nxt == S_CORE) && (r_state != S_CORE);
    end

    assign fetch_start_o = r_fetch_start;
    assign fetch_row_o   = r_row;
    assign fetch_rows_o  = r_rows;
    assign fetch_cols_o  = COL_W'(MAX_COL);
    assign core_start_o  = r_core_start;
    assign vga_en_o      = r_vga_en;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign state_o       = r_state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a 10-row frame in 4-row batches.
module tb_frame_sequencer;

    localparam int unsigned MAX_ROW   = 10;
    localparam int unsigned MAX_COL   = 320;
    localparam int unsigned TILE_ROWS = 4;
    localparam int unsigned ROW_W     = 9;
    localparam int unsigned COL_W     = 9;
    localparam int unsigned TMO_W     = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic             vga_run_i = 1'b0;
    logic             fetch_done_i = 1'b0;
    logic             core_done_i = 1'b0;
    logic             fetch_start_o;
    logic [ROW_W-1:0] fetch_row_o;
    logic [ROW_W-1:0] fetch_rows_o;
    logic [COL_W-1:0] fetch_cols_o;
    logic             core_start_o;
    logic             vga_en_o;
    logic             busy_o;
    logic             done_o;
    logic             error_o;
    logic [2:0]       state_o;

    int n_total = 0;
    int n_bad   = 0;
    int n_fs    = 0;
    int n_cs    = 0;
    int n_dn    = 0;

    frame_sequencer #(
        .MAX_ROW  (MAX_ROW),
        .MAX_COL  (MAX_COL),
        .TILE_ROWS(TILE_ROWS),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W),
        .TMO_W    (TMO_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .vga_run_i    (vga_run_i),
        .fetch_done_i (fetch_done_i),
        .core_done_i  (core_done_i),
        .fetch_start_o(fetch_start_o),
        .fetch_row_o  (fetch_row_o),
        .fetch_rows_o (fetch_rows_o),
        .fetch_cols_o (fetch_cols_o),
        .core_start_o (core_start_o),
        .vga_en_o     (vga_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (fetch_start_o) n_fs = n_fs + 1;
        if (core_start_o)  n_cs = n_cs + 1;
        if (done_o)        n_dn = n_dn + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_counts();
        n_fs = 0;
        n_cs = 0;
        n_dn = 0;
    endtask

    task automatic go();
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    // Entered in the fetch_start cycle; done strobes arrive 3 cycles after each start.
    task automatic run_batch(input int row, input int rows, input bit tog);
        chk("fetch_start", 32'(fetch_start_o), 1);
        chk("fetch_row", 32'(fetch_row_o), 32'(row));
        chk("fetch_rows", 32'(fetch_rows_o), 32'(rows));
        step(3);
        fetch_done_i = 1'b1;
        step(1);
        fetch_done_i = 1'b0;
        chk("core_start", 32'(core_start_o), 1);
        chk("state_core", 32'(state_o), 2);
        chk("row_hold", 32'(fetch_row_o), 32'(row));
        for (int i = 0; i < 3; i++) begin
            if (tog) start_i = ~start_i;
            step(1);
        end
        if (tog) start_i = 1'b0;
        core_done_i = 1'b1;
        step(1);
        core_done_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        k = 0;

        step(3);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_row", 32'(fetch_row_o), 0);
        chk("rst_rows", 32'(fetch_rows_o), 4);
        chk("rst_cols", 32'(fetch_cols_o), 320);
        chk("rst_pulses", 32'({fetch_start_o, core_start_o, done_o, vga_en_o, error_o}), 0);
        rst_n = 1'b1;
        step(1);

        // Plain frame, VGA off; start toggled during CORE of batch 2.
        clr_counts();
        go();
        chk("t1_state", 32'(state_o), 1);
        chk("t1_busy", 32'(busy_o), 1);
        run_batch(0, 4, 1'b0);
        run_batch(4, 4, 1'b1);
        run_batch(8, 2, 1'b0);
        chk("t1_done", 32'(done_o), 1);
        chk("t1_state_done", 32'(state_o), 4);
        chk("t1_busy_done", 32'(busy_o), 1);
        chk("t1_vga", 32'(vga_en_o), 0);
        step(1);
        chk("t1_idle", 32'(state_o), 0);
        chk("t1_busy_fall", 32'(busy_o), 0);
        chk("t1_done_fall", 32'(done_o), 0);
        step(3);
        chk("t1_nfs", 32'(n_fs), 3);
        chk("t1_ncs", 32'(n_cs), 3);
        chk("t1_ndn", 32'(n_dn), 1);

        // Frame with VGA handoff.
        clr_counts();
        vga_run_i = 1'b1;
        go();
        run_batch(0, 4, 1'b0);
        run_batch(4, 4, 1'b0);
        run_batch(8, 2, 1'b0);
        chk("t2_state_vga", 32'(state_o), 3);
        chk("t2_vga_on", 32'(vga_en_o), 1);
        chk("t2_no_done", 32'(done_o), 0);
        step(49);
        chk("t2_vga_hold", 32'(vga_en_o), 1);
        chk("t2_state_hold", 32'(state_o), 3);
        vga_run_i = 1'b0;
        step(1);
        chk("t2_done", 32'(done_o), 1);
        chk("t2_vga_off", 32'(vga_en_o), 0);
        step(1);
        chk("t2_idle", 32'(state_o), 0);
        chk("t2_ndn", 32'(n_dn), 1);

        // Abort together with core_done in batch 2.
        clr_counts();
        go();
        run_batch(0, 4, 1'b0);
        chk("t3_row2", 32'(fetch_row_o), 4);
        step(3);
        fetch_done_i = 1'b1;
        step(1);
        fetch_done_i = 1'b0;
        step(3);
        core_done_i = 1'b1;
        abort_i = 1'b1;
        step(1);
        core_done_i = 1'b0;
        abort_i = 1'b0;
        chk("t3_state", 32'(state_o), 0);
        chk("t3_busy", 32'(busy_o), 0);
        chk("t3_row", 32'(fetch_row_o), 0);
        chk("t3_rows", 32'(fetch_rows_o), 4);
        chk("t3_pulses", 32'({fetch_start_o, core_start_o, done_o}), 0);
        step(5);
        chk("t3_nfs", 32'(n_fs), 2);
        chk("t3_ncs", 32'(n_cs), 2);
        chk("t3_ndn", 32'(n_dn), 0);

        // Early fetch_done and stray core_done are ignored.
        go();
        fetch_done_i = 1'b1;
        core_done_i = 1'b1;
        step(1);
        fetch_done_i = 1'b0;
        chk("t4_state", 32'(state_o), 1);
        chk("t4_no_core", 32'(core_start_o), 0);
        step(1);
        core_done_i = 1'b0;
        chk("t4_state2", 32'(state_o), 1);
        fetch_done_i = 1'b1;
        step(1);
        fetch_done_i = 1'b0;
        chk("t4_core", 32'(state_o), 2);
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        chk("t4_abort", 32'(state_o), 0);

        // start held high across the frame gives exactly one run.
        clr_counts();
        start_i = 1'b1;
        step(1);
        run_batch(0, 4, 1'b0);
        run_batch(4, 4, 1'b0);
        run_batch(8, 2, 1'b0);
        chk("t6_done", 32'(done_o), 1);
        start_i = 1'b0;
        step(4);
        chk("t6_idle", 32'(state_o), 0);
        chk("t6_nfs", 32'(n_fs), 3);
        chk("t6_ndn", 32'(n_dn), 1);

`ifdef SEQ_TIMEOUT_EN
        // Watchdog: withhold fetch_done with start held.
        start_i = 1'b1;
        step(1);
        while (state_o != 3'd5 && k < 40) begin
            step(1);
            k++;
        end
        chk("t5_cycles", 32'(k), 15);
        chk("t5_state", 32'(state_o), 5);
        chk("t5_error", 32'(error_o), 1);
        chk("t5_no_pulse", 32'({fetch_start_o, core_start_o}), 0);
        start_i = 1'b0;
        step(1);
        chk("t5_idle", 32'(state_o), 0);
        chk("t5_sticky", 32'(error_o), 1);
        go();
        chk("t5_restart", 32'(state_o), 1);
        chk("t5_cleared", 32'(error_o), 0);
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
`else
        chk("no_err", 32'(error_o), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Top-level run sequencer for the image pipeline: it steps a frame through repeated FETCH→CORE batches of `TILE_ROWS` rows until `MAX_ROW` rows are processed, then hands the frame to the VGA stage. It issues one-cycle start pulses with row coordinates to the memory controller/preprocessor and core, and tracks their done strobes. It adds an abort path and an optional watchdog, and sits between the switch inputs and the datapath blocks.

## Interface

Parameters:
- `MAX_ROW`, 240: frame height in rows; ≥1.
- `MAX_COL`, 320: frame width; passed through on `fetch_cols_o`.
- `TILE_ROWS`, 4: rows per FETCH/CORE batch; 1..`MAX_ROW`.
- `ROW_W`, 9: row coordinate width; 2^ROW_W > `MAX_ROW`.
- `COL_W`, 9: column width; 2^COL_W > `MAX_COL`.
- `TMO_W`, 16: watchdog counter width (used only with `SEQ_TIMEOUT_EN`).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `start_i` in 1: level; run request, sampled in S_IDLE only.
- `abort_i` in 1: level; return to S_IDLE from any state.
- `vga_run_i` in 1: level; VGA display enable switch.
- `fetch_done_i` in 1: pulse; current batch is buffered.
- `core_done_i` in 1: pulse; current batch is processed.
- `fetch_start_o` out 1: one-cycle pulse; begin a batch fetch.
- `fetch_row_o` out ROW_W: first row of the batch; held stable through S_FETCH and S_CORE.
- `fetch_rows_o` out ROW_W: rows in the batch, = min(`TILE_ROWS`, `MAX_ROW`−row).
- `fetch_cols_o` out COL_W: constant `MAX_COL`.
- `core_start_o` out 1: one-cycle pulse; begin core processing.
- `vga_en_o` out 1: high in S_VGA_RUN.
- `busy_o` out 1: state ≠ S_IDLE.
- `done_o` out 1: one-cycle pulse in S_DONE.
- `error_o` out 1: sticky watchdog flag.
- `state_o` out 3: current state, for debug.

## Operation

States: S_IDLE=0, S_FETCH=1, S_CORE=2, S_VGA_RUN=3, S_DONE=4, S_ERR=5. All outputs are registered.

- **S_IDLE:** on `start_i`, clear `row` to 0 and go to S_FETCH.
- **S_FETCH:**
  - `fetch_start_o` pulses in the first cycle in this state.
  - On `fetch_done_i`, go to S_CORE.
- **S_CORE:**
  - `core_start_o` pulses in the first cycle in this state.
  - On `core_done_i`: if `row`+`TILE_ROWS` < `MAX_ROW`, then `row` += `TILE_ROWS` and go to S_FETCH.
  - Otherwise the frame is complete: go to S_VGA_RUN if `vga_run_i`=1, else go to S_DONE.
- **S_VGA_RUN:** stay while `vga_run_i`=1; on `vga_run_i`=0, go to S_DONE.
- **S_DONE:** go to S_IDLE after one cycle.
- **S_ERR:**
  - Stay while `start_i`=1.
  - When `start_i`=0, go to S_IDLE.
  - `error_o` is cleared on the next accepted `start_i` in S_IDLE.
- **Row arithmetic:** done at ROW_W+1 bits internally, so there is no wrap. The last batch is short when `MAX_ROW` mod `TILE_ROWS` ≠ 0.
- **Boundary rules:**
  - Done strobes that arrive in the same cycle as the matching start pulse are ignored.
  - Done strobes that arrive in other states are ignored.
  - `start_i` while `busy_o`=1 is ignored.
  - `abort_i` has priority over every transition and every done strobe. Next cycle: S_IDLE, `row`=0, and all pulses and `vga_en_o` are 0. `error_o` is unchanged.
  - Reset mid-frame behaves like abort and also clears `error_o`.

## Timing

- Reset values:
  - state = S_IDLE, `row` = 0.
  - `fetch_start_o`, `core_start_o`, `vga_en_o`, `busy_o`, `done_o`, `error_o` = 0.
  - `fetch_row_o` = 0, `fetch_rows_o` = min(`TILE_ROWS`, `MAX_ROW`), `fetch_cols_o` = `MAX_COL`.
- `start_i` sampled at edge N:
  - `busy_o`=1 and `state_o`=1 from N+1.
  - `fetch_start_o`=1 in cycle N+1 only.
- `fetch_done_i` at edge M → `core_start_o`=1 in cycle M+1.
- `core_done_i` (not last batch) at edge K:
  - `fetch_row_o` updates at K+1.
  - `fetch_start_o` pulses in cycle K+1.
- Minimum batch cycle is 4 clocks when done strobes arrive on the earliest accepted cycle.
- The `done_o` pulse coincides with `state_o`=4. `busy_o` falls one cycle later.

## Configuration

- `SEQ_TIMEOUT_EN` defined:
  - A TMO_W-bit counter clears on entry to S_FETCH or S_CORE and increments each cycle in those states.
  - If the counter reaches all-ones before the matching done strobe: go to S_ERR, `error_o`=1, pulses are suppressed.
- `SEQ_TIMEOUT_EN` undefined:
  - No counter.
  - S_ERR is unreachable; `error_o` is tied to 0.
  - The sequencer waits indefinitely for done strobes.

## Test plan

- `MAX_ROW`=10, `TILE_ROWS`=4, `vga_run_i`=0, start pulse, fetch/core done strobes 3 cycles after each start → three `fetch_start_o` pulses with (`fetch_row_o`, `fetch_rows_o`) = (0,4), (4,4), (8,2); three `core_start_o` pulses; one `done_o`; return to S_IDLE.
- Same setup with `vga_run_i`=1 → after the third `core_done_i`, `vga_en_o`=1 and holds for 50 cycles. Dropping `vga_run_i` → `done_o` pulses and `vga_en_o`=0.
- `abort_i` in S_CORE of batch 2, asserted in the same cycle as `core_done_i` → S_IDLE next cycle, no further start pulses, `fetch_row_o`=0.
- `fetch_done_i` asserted in the same cycle as `fetch_start_o`, plus `core_done_i` asserted during S_FETCH → both ignored; state stays S_FETCH.
- With `SEQ_TIMEOUT_EN` and `TMO_W`=4, withhold `fetch_done_i` → S_ERR after 15 cycles, `error_o`=1. Releasing `start_i` → S_IDLE with `error_o` still 1. A new start clears `error_o`.
- `start_i` held high across a whole frame → exactly one run. `start_i` toggled during S_CORE → no restart.
